hls_ctrl_initiator: RTL and testbench

Master-side driver for the `ap_ctrl_hs` block-level handshake used by the team's HLS accelerators, such as the locked MACC cores. It accepts a host command to launch an accelerator N times back-to-back. For each launch it drives `ap_start` per protocol, waits for completion, and captures the accelerator's `ap_vld`-qualified result. Each result is forwarded through a one-deep valid/ready output buffer. It sits between the host/CSR fabric and a single accelerator instance.

---
 rtl/hls_ctrl_initiator.sv | 153 +++++++++++++++
 tb/tb_hls_ctrl_initiator.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hls_ctrl_initiator.sv
// ap_ctrl_hs master: launches an HLS accelerator N times per host command and buffers each result one-deep.
// Accept->ap_start 2 cycles; a full output register stalls in HOLD; optional watchdog via HLS_CTRL_INIT_TIMEOUT_EN.
module hls_ctrl_initiator #(
   parameter int DW      = 32,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [CNT_W-1:0] cmd_count,
   output logic             acc_start,
   input  logic             acc_ready,
   input  logic             acc_done,
   input  logic             acc_idle,
   input  logic [DW-1:0]    acc_res,
   input  logic             acc_res_vld,
   output logic [DW-1:0]    res_data,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             busy,
   output logic             run_done,
   output logic             timeout_err
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WAIT_IDLE = 3'd1;
   localparam logic [2:0] S_START     = 3'd2;
   localparam logic [2:0] S_WAIT_DONE = 3'd3;
   localparam logic [2:0] S_HOLD      = 3'd4;

   logic [2:0]       state;
   logic [2:0]       state_nxt;
   logic [CNT_W-1:0] remaining;
   logic [DW-1:0]    cap;
   logic             accept;
   logic             in_launch;
   logic             launch_end;
   logic             out_free;
   logic             hold_load;
   logic             tmo_hit;

   // cmd_ready is gated by reset so it reads 0 for as long as reset is held.
   assign cmd_ready  = ap_rst_n && (state == S_IDLE);
   assign accept     = cmd_valid && cmd_ready;
   assign acc_start  = (state == S_START);
   assign busy       = (state != S_IDLE);
   assign in_launch  = (state == S_START) || (state == S_WAIT_DONE);
   assign launch_end = ((state == S_START) && acc_ready && acc_done) ||
                       ((state == S_WAIT_DONE) && acc_done);
   assign out_free   = !res_valid || res_ready;
   assign hold_load  = (state == S_HOLD) && out_free;

`ifdef HLS_CTRL_INIT_TIMEOUT_EN
   localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [TMR_W-1:0] tmr;
   logic             tmo_err_q;

   // A launch that completes on the limit cycle is honoured rather than aborted.
   assign tmo_hit     = in_launch && !launch_end && (tmr == TMR_W'(TIMEOUT - 1));
   assign timeout_err = tmo_err_q;

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         tmr       <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         if ((state == S_WAIT_IDLE) && acc_idle) begin
            tmr <= '0;
         end else if (in_launch) begin
            tmr <= tmr + 1'b1;
         end
         if (accept) begin
            tmo_err_q <= 1'b0;
         end else if (tmo_hit) begin
            tmo_err_q <= 1'b1;
         end
      end
   end
`else
   logic unused_cfg;

   assign unused_cfg  = (TIMEOUT < 2);
   assign tmo_hit     = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept && (cmd_count != '0)) state_nxt = S_WAIT_IDLE;
         end
         S_WAIT_IDLE: begin
            if (acc_idle) state_nxt = S_START;
         end
         S_START: begin
            if (acc_ready) state_nxt = acc_done ? S_HOLD : S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (acc_done) state_nxt = S_HOLD;
         end
         S_HOLD: begin
            if (out_free) state_nxt = (remaining == CNT_W'(1)) ? S_IDLE : S_WAIT_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (tmo_hit) state_nxt = S_IDLE;
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         state     <= S_IDLE;
         remaining <= '0;
         cap       <= '0;
         res_data  <= '0;
         res_valid <= 1'b0;
         run_done  <= 1'b0;
      end else begin
         state    <= state_nxt;
         run_done <= 1'b0;

         if (accept) begin
            remaining <= cmd_count;
            if (cmd_count == '0) run_done <= 1'b1;
         end

         // Last ap_vld beat of the launch wins; no beat leaves the result at 0.
         if ((state == S_WAIT_IDLE) && acc_idle) begin
            cap <= '0;
         end else if (in_launch && acc_res_vld) begin
            cap <= acc_res;
         end

         if (hold_load) begin
            res_data  <= cap;
            res_valid <= 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) run_done <= 1'b1;
         end else if (res_ready) begin
            res_valid <= 1'b0;
         end

         if (tmo_hit) begin
            remaining <= '0;
            run_done  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hls_ctrl_initiator.sv
// Directed bench for hls_ctrl_initiator: behavioural ap_ctrl_hs accelerator plus a result scoreboard.
module tb_hls_ctrl_initiator;

   localparam int DW    = 32;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [CNT_W-1:0] cmd_count;
   logic             acc_start;
   logic             acc_ready;
   logic             acc_done;
   logic             acc_idle;
   logic [DW-1:0]    acc_res;
   logic             acc_res_vld;
   logic [DW-1:0]    res_data;
   logic             res_valid;
   logic             res_ready;
   logic             busy;
   logic             run_done;
   logic             timeout_err;

   hls_ctrl_initiator #(.DW(DW), .CNT_W(CNT_W), .TIMEOUT(16)) dut (
      .ap_clk      (clk),
      .ap_rst_n    (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_count   (cmd_count),
      .acc_start   (acc_start),
      .acc_ready   (acc_ready),
      .acc_done    (acc_done),
      .acc_idle    (acc_idle),
      .acc_res     (acc_res),
      .acc_res_vld (acc_res_vld),
      .res_data    (res_data),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .busy        (busy),
      .run_done    (run_done),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] acc_vals[$];
   int            st_cyc_q[$];

   int  rdy_dly = 0, done_dly = 0;
   bit  never_done = 0, model_clr = 0, rr_want = 1;
   bit  active = 0, prev_busy = 0;
   int  t = 0, st_len = 0, last_len = 0;
   int  start_cnt = 0, rd_cnt = 0, beats = 0;
   int  last_rd_cyc = 0, busy_fall_cyc = 0, acc_ng = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor, scoreboard and accelerator model share one negedge process so ordering is fixed.
   initial forever begin
      @(negedge clk);
      res_ready = rr_want;
      if (acc_start) begin
         if (st_len == 0) begin
            start_cnt++;
            st_cyc_q.push_back(cyc);
         end
         st_len++;
      end else if (st_len != 0) begin
         last_len = st_len;
         st_len   = 0;
      end
      if (run_done) begin
         rd_cnt++;
         last_rd_cyc = cyc;
      end
      if (prev_busy && !busy) busy_fall_cyc = cyc;
      prev_busy = busy;
      if (res_valid && res_ready) begin
         beats++;
         if (exp_q.size() == 0) chk("unexpected_result", {32'd0, res_data}, 64'hFFFF_FFFF_FFFF_FFFF);
         else                   chk("res_data", {32'd0, res_data}, {32'd0, exp_q.pop_front()});
      end

      acc_ready   = 1'b0;
      acc_done    = 1'b0;
      acc_res_vld = 1'b0;
      if (model_clr) begin
         active    = 0;
         model_clr = 0;
      end else if (!active && acc_start) begin
         active = 1;
         t      = 0;
      end else if (active) begin
         t++;
      end
      if (active) begin
         if (t == rdy_dly) acc_ready = 1'b1;
         if (t == done_dly && !never_done) begin
            acc_done    = 1'b1;
            acc_res_vld = 1'b1;
            acc_res     = (acc_vals.size() != 0) ? acc_vals.pop_front() : 32'hDEAD_0000;
            active      = 0;
         end
      end
      acc_idle = !(active || acc_done);
   end

   task automatic send_cmd(input int n);
      cmd_valid = 1'b1;
      cmd_count = CNT_W'(n);
      acc_ng    = cyc;
      @(negedge clk); #2;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rd(input int target, input int budget);
      for (int i = 0; i < budget && rd_cnt < target; i++) begin
         @(negedge clk); #2;
      end
      chk("run_done_count", 64'(rd_cnt), 64'(target));
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk); #2;
      end
   endtask

   int s0, b0, r0, n0;

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_count = '0;
      acc_ready = 1'b0; acc_done = 1'b0; acc_idle = 1'b1; acc_res = '0; acc_res_vld = 1'b0;
      res_ready = 1'b1;
      step(3);
      chk("rst_cmd_ready", 64'(cmd_ready), 0);
      chk("rst_acc_start", 64'(acc_start), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_res_valid", 64'(res_valid), 0);
      chk("rst_res_data", 64'(res_data), 0);
      chk("rst_run_done", 64'(run_done), 0);
      chk("rst_timeout_err", 64'(timeout_err), 0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_cmd_ready", 64'(cmd_ready), 1);
      step(1);

      // Three back-to-back launches, ready at start+0, done at start+4.
      rdy_dly = 0; done_dly = 4; rr_want = 1;
      s0 = st_cyc_q.size(); b0 = beats; r0 = rd_cnt; n0 = start_cnt;
      acc_vals.push_back(32'h11); acc_vals.push_back(32'h22); acc_vals.push_back(32'h33);
      exp_q.push_back(32'h11);    exp_q.push_back(32'h22);    exp_q.push_back(32'h33);
      send_cmd(3);
      wait_rd(r0 + 1, 300);
      step(2);
      chk("t1_beats", 64'(beats - b0), 3);
      chk("t1_starts", 64'(start_cnt - n0), 3);
      chk("t1_accept_to_start", 64'(st_cyc_q[s0] - acc_ng), 2);
      chk("t1_start_spacing", 64'(st_cyc_q[s0 + 1] - st_cyc_q[s0]), 7);
      chk("t1_busy", 64'(busy), 0);
      chk("t1_sb_empty", 64'(exp_q.size()), 0);
      chk("t1_single_run_done", 64'(rd_cnt - r0), 1);

      // Stalled consumer: third launch must wait for the output register to drain.
      rdy_dly = 1; done_dly = 3; rr_want = 0;
      b0 = beats; r0 = rd_cnt; n0 = start_cnt;
      acc_vals.push_back(32'hA1); acc_vals.push_back(32'hA2); acc_vals.push_back(32'hA3);
      exp_q.push_back(32'hA1);    exp_q.push_back(32'hA2);    exp_q.push_back(32'hA3);
      send_cmd(3);
      step(40);
      chk("t2_starts_blocked", 64'(start_cnt - n0), 2);
      chk("t2_acc_start_low", 64'(acc_start), 0);
      chk("t2_res_valid_held", 64'(res_valid), 1);
      chk("t2_res_data_held", 64'(res_data), 64'hA1);
      chk("t2_busy", 64'(busy), 1);
      chk("t2_no_run_done", 64'(rd_cnt - r0), 0);
      rr_want = 1;
      wait_rd(r0 + 1, 200);
      step(2);
      chk("t2_beats", 64'(beats - b0), 3);
      chk("t2_starts", 64'(start_cnt - n0), 3);
      chk("t2_sb_empty", 64'(exp_q.size()), 0);

      // Ready and done together on the first start cycle.
      rdy_dly = 0; done_dly = 0;
      b0 = beats; r0 = rd_cnt;
      acc_vals.push_back(32'h5C); exp_q.push_back(32'h5C);
      send_cmd(1);
      wait_rd(r0 + 1, 100);
      step(2);
      chk("t3_start_len", 64'(last_len), 1);
      chk("t3_accept_to_run_done", 64'(last_rd_cyc - acc_ng), 4);
      chk("t3_beats", 64'(beats - b0), 1);
      chk("t3_sb_empty", 64'(exp_q.size()), 0);

      // Zero-length command.
      r0 = rd_cnt; n0 = start_cnt;
      send_cmd(0);
      wait_rd(r0 + 1, 20);
      chk("t4_run_done_latency", 64'(last_rd_cyc - acc_ng), 1);
      step(1);
      chk("t4_run_done_pulse", 64'(run_done), 0);
      chk("t4_no_start", 64'(start_cnt - n0), 0);
      chk("t4_busy", 64'(busy), 0);

`ifdef HLS_CTRL_INIT_TIMEOUT_EN
      // Accelerator hangs: watchdog aborts after 16 cycles in START/WAIT_DONE.
      never_done = 1; rdy_dly = 0;
      r0 = rd_cnt;
      send_cmd(1);
      wait_rd(r0 + 1, 100);
      chk("t5_timeout_err", 64'(timeout_err), 1);
      chk("t5_cmd_ready", 64'(cmd_ready), 1);
      chk("t5_busy", 64'(busy), 0);
      chk("t5_abort_cycles", 64'(busy_fall_cyc - st_cyc_q[st_cyc_q.size() - 1]), 16);
      never_done = 0; model_clr = 1; done_dly = 2;
      step(2);
      r0 = rd_cnt;
      acc_vals.push_back(32'h77); exp_q.push_back(32'h77);
      send_cmd(1);
      chk("t5_err_cleared", 64'(timeout_err), 0);
      wait_rd(r0 + 1, 100);
      step(2);
      chk("t5_sb_empty", 64'(exp_q.size()), 0);
`else
      chk("t5_timeout_err_tied", 64'(timeout_err), 0);
`endif

      // Reset while the second launch is in WAIT_DONE with a result pending.
      rdy_dly = 0; done_dly = 6; rr_want = 0;
      n0 = start_cnt;
      acc_vals.push_back(32'h91); acc_vals.push_back(32'h92);
      send_cmd(2);
      for (int i = 0; i < 100 && start_cnt < n0 + 2; i++) step(1);
      step(2);
      chk("t6_pre_res_valid", 64'(res_valid), 1);
      chk("t6_pre_busy", 64'(busy), 1);
      rst_n = 1'b0;
      step(1);
      chk("t6_acc_start", 64'(acc_start), 0);
      chk("t6_res_valid", 64'(res_valid), 0);
      chk("t6_res_data", 64'(res_data), 0);
      chk("t6_busy", 64'(busy), 0);
      chk("t6_run_done", 64'(run_done), 0);
      chk("t6_cmd_ready", 64'(cmd_ready), 0);
      chk("t6_timeout_err", 64'(timeout_err), 0);
      exp_q.delete(); acc_vals.delete();
      model_clr = 1; rr_want = 1;
      step(1);
      rst_n = 1'b1;
      #1;
      chk("t6_post_cmd_ready", 64'(cmd_ready), 1);
      step(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
